// File: rtl/step_result_checker.sv
// Steps the datapath instruction address through NUM_STEPS entries, lets each settle,
// and checks ALUResult against a programmable expected table.
module step_result_checker #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 32,
    parameter int NUM_STEPS = 3,
    parameter int SETTLE    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              exp_we,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [DATA_W-1:0] ALUResult,
    output logic [ADDR_W-1:0] sw,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_STEPS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  settle_cnt;
    logic [DATA_W-1:0] exp_tab [2**ADDR_W];
    logic              mismatch;
    logic              idle_like;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign mismatch  = (ALUResult != exp_tab[idx]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = APPLY;
            APPLY:      if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
            CHECK:      state_nxt = (idx == LAST_IDX) ? DONE : APPLY;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == APPLY) || (state == CHECK);
        done = (state == DONE);
        pass = done && (err_count == '0);
    end

    // Table is deliberately left out of reset so a mid-run abort keeps the programmed values.
    always_ff @(posedge clk) begin
        if (exp_we && idle_like) exp_tab[exp_addr] <= exp_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw         <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sw         <= '0;
                        idx        <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_addr  <= '0;
                    end
                end
                APPLY: settle_cnt <= settle_cnt + 1'b1;
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_addr  <= idx;
                        end
                    end
                    // sw stays on the last address once the run completes
                    if (idx != LAST_IDX) begin
                        idx        <= idx + 1'b1;
                        sw         <= idx + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_step_result_checker.sv
// Directed bench for step_result_checker: table of whole-run vectors plus
// hand-written reset and mid-run corner cases.
module tb_step_result_checker;

    logic        clk = 1'b0;
    logic        rst, start, exp_we;
    logic [1:0]  exp_addr;
    logic [31:0] exp_data, ALUResult;
    logic [1:0]  sw;
    logic        busy, done, pass, fail_valid;
    logic [2:0]  err_count;
    logic [1:0]  fail_addr;

    int total = 0;
    int bad   = 0;
    bit fault_mode = 1'b0;

    logic [31:0] model_tab [4];
    logic [1:0]  sw_seq [9];

    typedef struct {
        bit          fault;
        bit          inject;
        logic [2:0]  err;
        bit          fv;
        logic [1:0]  fa;
        bit          ps;
    } run_vec_t;

    run_vec_t vecs [5];

    always #5 clk = ~clk;

    step_result_checker dut (
        .clk(clk), .rst(rst), .start(start), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .ALUResult(ALUResult), .sw(sw), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_valid(fail_valid), .fail_addr(fail_addr)
    );

    // Datapath stand-in: result is a lookup of sw, optionally corrupted at sw=1 and sw=2.
    always_comb begin
        ALUResult = model_tab[sw];
        if (fault_mode && sw == 2'd1) ALUResult = 32'h0000000B;
        if (fault_mode && sw == 2'd2) ALUResult = 32'h00000000;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sw"}, 32'(sw), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err"}, 32'(err_count), 32'd0);
        chk({tag, "_fv"}, 32'(fail_valid), 32'd0);
        chk({tag, "_fa"}, 32'(fail_addr), 32'd0);
    endtask

    task automatic write_exp(input logic [1:0] a, input logic [31:0] d);
        exp_we = 1'b1; exp_addr = a; exp_data = d;
        step();
        exp_we = 1'b0;
    endtask

    // Pulses start (edge E0), checks the sw/busy trace through E8 and the result at E9.
    task automatic run_and_check(input string tag, input run_vec_t v);
        fault_mode = v.fault;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_e0_err_clr"}, 32'(err_count), 32'd0);
        chk({tag, "_e0_fv_clr"}, 32'(fail_valid), 32'd0);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s_sw_e%0d", tag, k), 32'(sw), 32'(sw_seq[k]));
            chk($sformatf("%s_busy_e%0d", tag, k), 32'(busy), 32'd1);
            chk($sformatf("%s_done_e%0d", tag, k), 32'(done), 32'd0);
            if (v.inject && k == 3) begin
                start = 1'b1; exp_we = 1'b1; exp_addr = 2'd0; exp_data = 32'hDEADBEEF;
            end
            if (k < 8) begin
                step();
                start = 1'b0; exp_we = 1'b0;
            end
        end
        step();
        chk({tag, "_done_e9"}, 32'(done), 32'd1);
        chk({tag, "_busy_e9"}, 32'(busy), 32'd0);
        chk({tag, "_sw_e9"}, 32'(sw), 32'd2);
        chk({tag, "_err"}, 32'(err_count), 32'(v.err));
        chk({tag, "_fv"}, 32'(fail_valid), 32'(v.fv));
        if (v.fv) chk({tag, "_fa"}, 32'(fail_addr), 32'(v.fa));
        chk({tag, "_pass"}, 32'(pass), 32'(v.ps));
        step();
        chk({tag, "_done_hold"}, 32'(done), 32'd1);
        chk({tag, "_err_hold"}, 32'(err_count), 32'(v.err));
    endtask

    initial begin
        model_tab[0] = 32'h00000006; model_tab[1] = 32'h0000000A;
        model_tab[2] = 32'hFFFFFFFC; model_tab[3] = 32'h00000000;
        sw_seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        //          fault inject err   fv fa    pass
        vecs[0] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1};  // passing run
        vecs[1] = '{1'b1, 1'b0, 3'd2, 1'b1, 2'd1, 1'b0};  // two failing steps
        vecs[2] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1};  // restart from DONE
        vecs[3] = '{1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 1'b1};  // start/write ignored mid-run
        vecs[4] = '{1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1};  // table still intact

        rst = 1'b1; start = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        step();
        step();
        chk_reset_vals("rst");
        rst = 1'b0; start = 1'b0;
        step();
        chk_reset_vals("idle");

        write_exp(2'd0, 32'h00000006);
        write_exp(2'd1, 32'h0000000A);
        write_exp(2'd2, 32'hFFFFFFFC);

        for (int i = 0; i < 5; i++) run_and_check($sformatf("run%0d", i), vecs[i]);

        // Abort mid-run: rst sampled at the edge after E4.
        fault_mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid_busy_e4", 32'(busy), 32'd1);
        chk("mid_sw_e4", 32'(sw), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("midrst");
        step();
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        run_and_check("after_rst", vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_result_checker.md
# step_result_checker

Self-checking instruction stepper for the single-cycle datapath `top`. It drives the 2-bit instruction-memory address `sw` through a programmed number of steps and waits a settle interval at each step. It then compares the datapath's `ALUResult` against an expected-value table and reports the error count, the first failing address and pass/fail. It is the on-chip counterpart to the simulation stimulus: it consumes `top` outputs and drives `top`'s `sw` input, so a board build can verify the datapath without a simulator.

## Interface
Parameters:
- `ADDR_W`, default 2: width of `sw` and of the expected-table index.
- `DATA_W`, default 32: width of the compared datapath result.
- `NUM_STEPS`, default 3: instructions checked per run; legal range 1..2^ADDR_W.
- `SETTLE`, default 2: cycles `sw` is held before sampling; legal range ≥1.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `exp_we` in 1: expected-table write strobe.
- `exp_addr` in ADDR_W: expected-table write index.
- `exp_data` in DATA_W: expected `ALUResult` for that index.
- `ALUResult` in DATA_W: datapath result from `top`.
- `sw` out ADDR_W: instruction address to `top`; registered.
- `busy` out 1: high in APPLY and CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: valid when `done`=1; 1 when `err_count`==0.
- `err_count` out ADDR_W+1: mismatches in the current or last run.
- `fail_valid` out 1: at least one mismatch recorded this run.
- `fail_addr` out ADDR_W: index of the first mismatch.

## Operation
- Expected table: 2^ADDR_W × DATA_W registers.
  - Written when `exp_we`=1 and state is IDLE or DONE.
  - Writes in APPLY or CHECK are ignored.
  - Not cleared by `rst`; contents are undefined until written.
- FSM states:
  - IDLE: if `start`=1, clear `err_count`, `fail_valid`, `fail_addr` and `idx`; set `sw`=0 and `settle_cnt`=0; go to APPLY.
  - APPLY: hold `sw`=`idx`. Increment `settle_cnt`; when `settle_cnt`==SETTLE-1, go to CHECK.
  - CHECK: compare `ALUResult` against `exp[idx]` (full DATA_W equality).
    - On mismatch, increment `err_count`. If `fail_valid`=0, set `fail_valid`=1 and `fail_addr`=`idx`.
    - If `idx`==NUM_STEPS-1, go to DONE and leave `sw` unchanged.
    - Otherwise increment `idx`, set `sw`=`idx`+1, clear `settle_cnt`, and go to APPLY.
  - DONE: `done`=1; results held. `start`=1 behaves exactly as `start` in IDLE (new run; results cleared).
- `start` in APPLY or CHECK is ignored; a run cannot be restarted mid-run except via `rst`.
- `err_count` cannot overflow, since its maximum is NUM_STEPS ≤ 2^ADDR_W.
- `pass` is combinational from state and count: `pass` = `done` & (`err_count`==0).
- `rst` mid-run aborts immediately: state returns to IDLE and all outputs take their reset values; the expected table is untouched.

## Timing
- Reset values: `sw`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_addr`=0; internal state IDLE, `idx`=0, `settle_cnt`=0.
- Edge E0 samples `start`=1: from E0, state is APPLY, `sw`=0, `busy`=1.
- Each step occupies SETTLE cycles in APPLY plus 1 cycle in CHECK.
  - `ALUResult` is sampled at the CHECK-exit edge, SETTLE+1 edges after `sw` changed.
  - With the default `SETTLE`=2, the step-0 sample is at E3.
- `sw` changes on the same edge that leaves CHECK (non-final step).
- `done` rises NUM_STEPS×(SETTLE+1) edges after E0; with defaults, at E9.
  - The updated `err_count` is visible in the same cycle as `done`.
- Combinational path `sw`→`top`→`ALUResult` must close within one cycle; SETTLE absorbs any extra registers.

## Test plan
1. **Reset values:** assert `rst` for 2 cycles with `start`=1 → all outputs hold their reset values and `busy`=0.
2. **Passing run:** write table {0:0x00000006, 1:0x0000000A, 2:0xFFFFFFFC}; model `ALUResult` as the table lookup of `sw`; pulse `start` → `sw` sequence 0,0,0,1,1,1,2,2,2; `done`=1 at E9; `pass`=1; `err_count`=0; `fail_valid`=0.
3. **Failing steps:** as scenario 2, but the model returns 0x0000000B at `sw`=1 and 0 at `sw`=2 → `err_count`=2, `fail_valid`=1, `fail_addr`=1, `pass`=0.
4. **Ignored inputs mid-run:** `start` pulse and `exp_we` write (addr 0, data 0xDEADBEEF) while `busy`=1 → run timing unchanged; the table still holds 0x00000006 (confirmed by a clean rerun).
5. **Reset mid-run:** assert `rst` at E4 → outputs return to reset values at E5. A subsequent `start` runs the full 9-cycle sequence with the table preserved.
6. **Restart from DONE:** after scenario 3, `start` from DONE with a correct model → counters clear on the start edge; the new run ends with `pass`=1, `err_count`=0.
